// File: rtl/sd_sector_reader.sv
// sd_sector_reader: walks one 512-byte sector as 256 word reads on the content
// port and serializes the words into a valid/ready byte stream.
// Optional build macro SD_SECTOR_READER_CRC16_EN appends CRC16-CCITT
// (crc[15:8] then crc[7:0]) after the data bytes.
module sd_sector_reader #(
   parameter int unsigned SECTOR_W  = 32,
   parameter int unsigned LSB_FIRST = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [SECTOR_W-1:0] sector,
   input  logic                abort,
   output logic                busy,
   output logic                rdreq,
   output logic [SECTOR_W+7:0] rdaddr,
   input  logic [15:0]         rddata,
   output logic                out_valid,
   output logic [7:0]          out_data,
   input  logic                out_ready,
   output logic                out_last
);

`ifdef SD_SECTOR_READER_CRC16_EN
   typedef enum logic [2:0] {StIdle, StFetch, StWait, StLo, StHi, StCrc0, StCrc1} state_e;
`else
   typedef enum logic [2:0] {StIdle, StFetch, StWait, StLo, StHi} state_e;
`endif

   state_e              state_q, state_d;
   logic [SECTOR_W-1:0] sector_q, sector_d;
   logic [7:0]          idx_q, idx_d;
   logic [15:0]         word_q, word_d;
   logic [7:0]          first_byte, second_byte;
   logic                last_word;

`ifdef SD_SECTOR_READER_CRC16_EN
   logic [15:0]         crc_q, crc_d;

   // CRC16-CCITT, one byte, MSB first, no reflection
   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         if (r[15] ^ b[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
         else              r = {r[14:0], 1'b0};
      end
      return r;
   endfunction
`endif

   assign first_byte  = (LSB_FIRST != 0) ? word_q[7:0]  : word_q[15:8];
   assign second_byte = (LSB_FIRST != 0) ? word_q[15:8] : word_q[7:0];
   assign last_word   = (idx_q == 8'hFF);
   assign busy        = (state_q != StIdle);

   // Next-state, prefetch strobe and stream outputs
   always_comb begin
      state_d   = state_q;
      sector_d  = sector_q;
      idx_d     = idx_q;
      word_d    = word_q;
`ifdef SD_SECTOR_READER_CRC16_EN
      crc_d     = crc_q;
`endif
      rdreq     = 1'b0;
      rdaddr    = {sector_q, idx_q};
      out_valid = 1'b0;
      out_data  = 8'h00;
      out_last  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d  = StFetch;
               sector_d = sector;
               idx_d    = 8'h00;
`ifdef SD_SECTOR_READER_CRC16_EN
               crc_d    = 16'h0000;
`endif
            end
         end
         StFetch: begin
            rdreq   = 1'b1;
            state_d = StWait;
         end
         StWait: begin
            word_d  = rddata;
            state_d = StLo;
         end
         StLo: begin
            out_valid = 1'b1;
            out_data  = first_byte;
            // Address of the next word, so the prefetch lands while HI is shown
            rdaddr    = {sector_q, idx_q + 8'd1};
            if (out_ready) begin
               rdreq   = !last_word;
               state_d = StHi;
`ifdef SD_SECTOR_READER_CRC16_EN
               crc_d   = crc16_byte(crc_q, first_byte);
`endif
            end
         end
         StHi: begin
            out_valid = 1'b1;
            out_data  = second_byte;
`ifndef SD_SECTOR_READER_CRC16_EN
            out_last  = last_word;
`endif
            if (out_ready) begin
`ifdef SD_SECTOR_READER_CRC16_EN
               crc_d = crc16_byte(crc_q, second_byte);
`endif
               if (!last_word) begin
                  word_d  = rddata;
                  idx_d   = idx_q + 8'd1;
                  state_d = StLo;
               end else begin
`ifdef SD_SECTOR_READER_CRC16_EN
                  state_d = StCrc0;
`else
                  state_d = StIdle;
`endif
               end
            end
         end
`ifdef SD_SECTOR_READER_CRC16_EN
         StCrc0: begin
            out_valid = 1'b1;
            out_data  = crc_q[15:8];
            if (out_ready) state_d = StCrc1;
         end
         StCrc1: begin
            out_valid = 1'b1;
            out_data  = crc_q[7:0];
            out_last  = 1'b1;
            if (out_ready) state_d = StIdle;
         end
`endif
         default: state_d = StIdle;
      endcase
      // Abort overrides everything; registers other than state are frozen so
      // rdaddr does not move while idle.
      if (abort) begin
         state_d  = StIdle;
         rdreq    = 1'b0;
         sector_d = sector_q;
         idx_d    = idx_q;
         word_d   = word_q;
`ifdef SD_SECTOR_READER_CRC16_EN
         crc_d    = crc_q;
`endif
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         sector_q <= '0;
         idx_q    <= 8'h00;
         word_q   <= 16'h0000;
`ifdef SD_SECTOR_READER_CRC16_EN
         crc_q    <= 16'h0000;
`endif
      end else begin
         state_q  <= state_d;
         sector_q <= sector_d;
         idx_q    <= idx_d;
         word_q   <= word_d;
`ifdef SD_SECTOR_READER_CRC16_EN
         crc_q    <= crc_d;
`endif
      end
   end

endmodule

// File: tb/tb_sd_sector_reader.sv
// tb_sd_sector_reader: table vectors, hand sequences and random backpressure
// checked against a byte-level model of sector content and the stream rules.
module tb_sd_sector_reader;

`ifdef SD_SECTOR_READER_CRC16_EN
   localparam int STREAM_LEN = 514;
`else
   localparam int STREAM_LEN = 512;
`endif

   logic        clk = 1'b0;
   logic        rst_n, start, abort, out_ready;
   logic [31:0] sector;
   logic        busy, rdreq, out_valid, out_last;
   logic [39:0] rdaddr;
   logic [15:0] rddata = 16'h0000;
   logic [7:0]  out_data;

   int checks, errors;

   logic [7:0] got_q[$];
   logic       got_last_q[$];
   logic [7:0] want_q[$];
   logic [7:0] ref_q[$];
   int rdreq_cnt, addr_err, stall_err, first_rdreq_cyc, first_valid_cyc;
   int last_hs_cyc, end_cyc, timeout;
   bit aborted;

   typedef struct {
      logic [31:0] sec;
      int          idx;
      logic [7:0]  want;
   } vec_t;
   vec_t tbl[13];

   sd_sector_reader #(.SECTOR_W(32), .LSB_FIRST(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sector(sector), .abort(abort),
      .busy(busy), .rdreq(rdreq), .rdaddr(rdaddr), .rddata(rddata),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .out_last(out_last)
   );

   always #5 clk = ~clk;

   // Sector content: a few known boot-sector bytes, otherwise a hash
   function automatic logic [7:0] byte_at(logic [31:0] s, int i);
      logic [31:0] h;
      case (s)
         32'h0000: begin
            if (i == 446) return 8'h00;
            if (i == 447) return 8'h82;
            if (i == 510) return 8'h55;
            if (i == 511) return 8'hAA;
         end
         32'h2000: begin
            if (i == 0) return 8'hEB;
            if (i == 1) return 8'h00;
            if (i == 2) return 8'h90;
            if (i == 3) return 8'h20;
         end
         32'h4100: begin
            if (i == 0) return 8'h48;
            if (i == 1) return 8'h65;
            if (i == 2) return 8'h6C;
            if (i == 3) return 8'h6C;
            if (i == 4) return 8'h6F;
         end
         32'h1234: return 8'h00;
         default: ;
      endcase
      h = s * 32'd29 + 32'(i) * 32'd7 + 32'(i >> 8) * 32'd3 + 32'd1;
      return h[7:0];
   endfunction

   // Little-endian word view of the content
   function automatic logic [15:0] word_at(logic [39:0] a);
      logic [31:0] s;
      int k;
      s = a[39:8];
      k = int'(a[7:0]);
      return {byte_at(s, 2 * k + 1), byte_at(s, 2 * k)};
   endfunction

   function automatic logic [15:0] crc_upd(logic [15:0] c, logic [7:0] b);
      c = c ^ {b, 8'h00};
      for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      return c;
   endfunction

   // Content port: synchronous, updates only after rdreq
   always @(posedge clk) if (rdreq) rddata <= word_at(rdaddr);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", name, act, want);
      end
   endtask

   task automatic build_want(input logic [31:0] s);
      logic [15:0] c;
      logic [7:0]  b;
      want_q.delete();
      c = 16'h0000;
      for (int i = 0; i < 512; i++) begin
         b = byte_at(s, i);
         want_q.push_back(b);
         c = crc_upd(c, b);
      end
`ifdef SD_SECTOR_READER_CRC16_EN
      want_q.push_back(c[15:8]);
      want_q.push_back(c[7:0]);
`endif
   endtask

   // Mismatches of captured stream (data and last flag) against the model
   function automatic int stream_mism();
      int m;
      m = (got_q.size() == want_q.size()) ? 0 : 1;
      for (int i = 0; i < got_q.size() && i < want_q.size(); i++) begin
         if (got_q[i] !== want_q[i]) m++;
         if (got_last_q[i] !== (i == want_q.size() - 1)) m++;
      end
      return m;
   endfunction

   task automatic run_sector(input logic [31:0] s, input bit rnd, input int abort_at);
      int   cyc;
      bit   done, pv, pr, pl;
      logic [7:0] pd;
      got_q.delete();
      got_last_q.delete();
      rdreq_cnt = 0; addr_err = 0; stall_err = 0; timeout = 0; aborted = 0;
      first_rdreq_cyc = -1; first_valid_cyc = -1; last_hs_cyc = -1; end_cyc = -1;
      @(posedge clk); #1;
      start = 1'b1; sector = s; out_ready = 1'b1; abort = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      pv = 0; pr = 0; pl = 0; pd = 8'h00; cyc = 1; done = 0;
      while (!done) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         abort = (abort_at >= 0 && got_q.size() == abort_at);
         @(negedge clk);
         if (rdreq) begin
            if (first_rdreq_cyc < 0) first_rdreq_cyc = cyc;
            if (rdaddr !== {s, rdreq_cnt[7:0]}) addr_err++;
            rdreq_cnt++;
         end
         if (pv && !pr && !(out_valid && out_data === pd && out_last === pl)) stall_err++;
         if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (abort) begin
            aborted = out_valid;
            done = 1;
         end else if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            got_last_q.push_back(out_last);
            last_hs_cyc = cyc;
         end
         pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
         @(posedge clk); #1;
         abort = 1'b0;
         if (!done && !busy) begin
            end_cyc = cyc;
            done = 1;
         end
         if (cyc > 4000) begin
            timeout = 1;
            done = 1;
         end
         cyc++;
      end
   endtask

   initial begin
      logic [31:0] cur;
      int m;
      checks = 0; errors = 0;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0; sector = 32'h0;
      tbl[0]  = '{32'h0000, 446, 8'h00};
      tbl[1]  = '{32'h0000, 447, 8'h82};
      tbl[2]  = '{32'h0000, 510, 8'h55};
      tbl[3]  = '{32'h0000, 511, 8'hAA};
      tbl[4]  = '{32'h4100, 0, 8'h48};
      tbl[5]  = '{32'h4100, 1, 8'h65};
      tbl[6]  = '{32'h4100, 2, 8'h6C};
      tbl[7]  = '{32'h4100, 3, 8'h6C};
      tbl[8]  = '{32'h4100, 4, 8'h6F};
      tbl[9]  = '{32'h2000, 0, 8'hEB};
      tbl[10] = '{32'h2000, 1, 8'h00};
      tbl[11] = '{32'h2000, 2, 8'h90};
      tbl[12] = '{32'h2000, 3, 8'h20};

      #2;
      chk("reset_busy", busy, 0);
      chk("reset_rdreq", rdreq, 0);
      chk("reset_rdaddr", rdaddr, 0);
      chk("reset_valid", out_valid, 0);
      chk("reset_data", out_data, 0);
      chk("reset_last", out_last, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Sector 0, no stalls: timing and whole stream
      run_sector(32'h0, 0, -1);
      build_want(32'h0);
      chk("sec0_timeout", timeout, 0);
      chk("sec0_first_rdreq_cyc", first_rdreq_cyc, 1);
      chk("sec0_rdaddr_seq_err", addr_err, 0);
      chk("sec0_first_valid_cyc", first_valid_cyc, 3);
      chk("sec0_last_hs_cyc", last_hs_cyc, 2 + STREAM_LEN);
      chk("sec0_busy_fall_cyc", end_cyc, 2 + STREAM_LEN);
      chk("sec0_len", got_q.size(), STREAM_LEN);
      chk("sec0_rdreq_cnt", rdreq_cnt, 256);
      chk("sec0_stream_mism", stream_mism(), 0);

      // Table vectors against known sector bytes
      cur = 32'hFFFF_FFFF;
      for (int n = 0; n < 13; n++) begin
         if (tbl[n].sec !== cur) begin
            run_sector(tbl[n].sec, 0, -1);
            cur = tbl[n].sec;
            if (cur == 32'h2000) ref_q = got_q;
         end
         chk($sformatf("tbl_sec%0h_byte%0d", tbl[n].sec, tbl[n].idx),
             (tbl[n].idx < got_q.size()) ? got_q[tbl[n].idx] : 8'hxx, tbl[n].want);
      end
      chk("sec2000_rdaddr_seq_err", addr_err, 0);

      // Random backpressure on sector 0x2000
      run_sector(32'h2000, 1, -1);
      build_want(32'h2000);
      m = (got_q.size() == ref_q.size()) ? 0 : 1;
      for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
         if (got_q[i] !== ref_q[i]) m++;
      chk("rnd_timeout", timeout, 0);
      chk("rnd_vs_nostall_mism", m, 0);
      chk("rnd_stream_mism", stream_mism(), 0);
      chk("rnd_rdreq_cnt", rdreq_cnt, 256);
      chk("rnd_rdaddr_seq_err", addr_err, 0);
      chk("rnd_stall_unstable", stall_err, 0);

      // Abort while byte 100 is presented
      run_sector(32'h4100, 0, 100);
      chk("abort_on_valid_byte", aborted, 1);
      chk("abort_bytes_before", got_q.size(), 100);
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_valid", out_valid, 0);
      chk("abort_rdreq", rdreq, 0);
      run_sector(32'h0, 0, -1);
      build_want(32'h0);
      chk("after_abort_stream_mism", stream_mism(), 0);

      // Abort together with start in idle: start ignored
      @(posedge clk); #1;
      start = 1'b1; abort = 1'b1; sector = 32'h4100;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("abort_start_busy", busy, 0);
      chk("abort_start_rdreq", rdreq, 0);

      // Asynchronous reset mid-sector
      @(posedge clk); #1;
      start = 1'b1; sector = 32'h4100; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_valid", out_valid, 0);
      chk("midrst_rdaddr", rdaddr, 0);
      chk("midrst_data", out_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_sector(32'h4100, 0, -1);
      build_want(32'h4100);
      chk("after_rst_stream_mism", stream_mism(), 0);

      // All-zero sector: tail bytes and last flag position
      run_sector(32'h1234, 0, -1);
      build_want(32'h1234);
      chk("zero_len", got_q.size(), STREAM_LEN);
      chk("zero_tail0", (got_q.size() == STREAM_LEN) ? got_q[STREAM_LEN-2] : 8'hxx, 8'h00);
      chk("zero_tail1", (got_q.size() == STREAM_LEN) ? got_q[STREAM_LEN-1] : 8'hxx, 8'h00);
      chk("zero_last_pos",
          (got_q.size() == STREAM_LEN) ? got_last_q[STREAM_LEN-1] : 1'bx, 1'b1);
      chk("zero_stream_mism", stream_mism(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
